// File: rtl/dp_pkg.sv
// Shared encodings for the parametrised multicycle datapath: ALU operations,
// compare codes, selector codes, IR opcode width and multiplier FSM states.
package dp_pkg;

    // ALU operation codes; any code not listed produces zero.
    typedef enum logic [3:0] {
        AluAdd   = 4'd0,
        AluSub   = 4'd1,
        AluAnd   = 4'd2,
        AluOr    = 4'd3,
        AluNot   = 4'd4,
        AluTcp   = 4'd5,
        AluShl   = 4'd6,
        AluShr   = 4'd7,
        AluLhi   = 4'd8,
        AluPassB = 4'd9
    } alu_op_e;

    // Signed A/B comparison result.
    localparam logic [1:0] CmpEq = 2'b00;
    localparam logic [1:0] CmpGt = 2'b01;
    localparam logic [1:0] CmpLt = 2'b10;

    // Register-file destination select.
    localparam logic [1:0] DstRd   = 2'd0;
    localparam logic [1:0] DstRt   = 2'd1;
    localparam logic [1:0] DstLink = 2'd2;
    localparam logic [1:0] DstNone = 2'd3;

    // Register-file write-data select.
    localparam logic [1:0] WsrcAluOut = 2'd0;
    localparam logic [1:0] WsrcMdr    = 2'd1;
    localparam logic [1:0] WsrcSeq    = 2'd2;
    localparam logic [1:0] WsrcZero   = 2'd3;

    // ALU operand A select.
    localparam logic [1:0] SrcAReg  = 2'd0;
    localparam logic [1:0] SrcAPc   = 2'd1;
    localparam logic [1:0] SrcASeq  = 2'd2;
    localparam logic [1:0] SrcAZero = 2'd3;

    // ALU operand B select.
    localparam logic [1:0] SrcBReg  = 2'd0;
    localparam logic [1:0] SrcBOne  = 2'd1;
    localparam logic [1:0] SrcBImm  = 2'd2;
    localparam logic [1:0] SrcBZero = 2'd3;

    // Opcode occupies the top bits of IR; rs/rt/rd follow downwards.
    localparam int unsigned OPC_BITS = 4;

    typedef enum logic [1:0] {
        MulIdle = 2'd0,
        MulRun  = 2'd1,
        MulDone = 2'd2
    } mul_state_e;

endpackage

// File: rtl/dp_iter_mul.sv
// Iterative shift-add multiplier: Width cycles of RUN, then a one-cycle DONE.
// Operands are captured on the start edge. product/load present the final sum
// combinationally so the owner can latch it on the edge that enters DONE.
module dp_iter_mul #(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [Width-1:0] op_a,
    input  logic [Width-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             load,
    output logic [Width-1:0] product
);
    import dp_pkg::*;

    localparam int unsigned CntW = $clog2(Width);

    mul_state_e       state_q;
    logic [Width-1:0] mcand_q;
    logic [Width-1:0] mplier_q;
    logic [Width-1:0] acc_q;
    logic [CntW-1:0]  cnt_q;
    logic [Width-1:0] acc_step;

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign product  = acc_step;
    assign load     = (state_q == MulRun) && (cnt_q == CntW'(Width - 1));

    // Multiplier FSM with registered busy/done; start is honoured only in idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= MulIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            unique case (state_q)
                MulIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand_q  <= op_a;
                        mplier_q <= op_b;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy     <= 1'b1;
                        state_q  <= MulRun;
                    end
                end
                MulRun: begin
                    acc_q    <= acc_step;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (load) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= MulDone;
                    end
                end
                MulDone: begin
                    done    <= 1'b0;
                    state_q <= MulIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= MulIdle;
                end
            endcase
        end
    end

endmodule

// File: rtl/mc_datapath_param.sv
// Parametrised multicycle datapath: IR/MDR/A/B/ALUOut latches, register file,
// ALU and an iterative multiplier that owns ALUOut while it runs.
// Build option: define DP_RF_BYPASS_EN to forward same-cycle RF write data to
// the RF read ports; left undefined, reads see the old value until the edge.
module mc_datapath_param #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned NUM_REGS  = 4,
    parameter int unsigned IMM_BITS  = 8,
    parameter int unsigned LINK_REG  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] inst_addr,
    input  logic [WORD_SIZE-1:0] inst_seq_addr,
    input  logic [WORD_SIZE-1:0] instruction,
    input  logic [WORD_SIZE-1:0] mem_data,
    input  logic                 ir_write,
    input  logic                 mdr_write,
    input  logic                 ab_write,
    input  logic                 alu_out_write,
    input  logic                 reg_write,
    input  logic [1:0]           reg_dst,
    input  logic [1:0]           reg_wsrc,
    input  logic [3:0]           alu_op,
    input  logic [1:0]           alu_src_a,
    input  logic [1:0]           alu_src_b,
    input  logic                 mul_start,
    output logic                 mul_busy,
    output logic                 mul_done,
    output logic [WORD_SIZE-1:0] output_data,
    output logic [WORD_SIZE-1:0] rf_addr,
    output logic [WORD_SIZE-1:0] rf_data,
    output logic [WORD_SIZE-1:0] alu_result,
    output logic [WORD_SIZE-1:0] alu_out,
    output logic [1:0]           alu_cmp
);
    import dp_pkg::*;

    localparam int unsigned W      = WORD_SIZE;
    localparam int unsigned RA     = $clog2(NUM_REGS);
    localparam int unsigned RS_LSB = W - OPC_BITS - RA;
    localparam int unsigned RT_LSB = RS_LSB - RA;
    localparam int unsigned RD_LSB = RT_LSB - RA;

    logic [W-1:0]  ir_q, mdr_q, a_q, b_q, alu_out_q;
    logic [W-1:0]  rf_q [NUM_REGS];
    logic [RA-1:0] rs, rt, rd, wr_idx;
    logic [W-1:0]  imm_sext, wr_data, rs_val, rt_val, op_a, op_b, mul_product;
    logic          wr_en, mul_load;
    logic          unused_opcode;

    assign rs            = ir_q[RS_LSB +: RA];
    assign rt            = ir_q[RT_LSB +: RA];
    assign rd            = ir_q[RD_LSB +: RA];
    assign imm_sext      = {{(W - IMM_BITS){ir_q[IMM_BITS-1]}}, ir_q[IMM_BITS-1:0]};
    assign unused_opcode = ^ir_q[W-1:W-OPC_BITS];

    // RF write port decode; DstNone masks reg_write.
    always_comb begin
        wr_en  = reg_write && (reg_dst != DstNone);
        wr_idx = rd;
        case (reg_dst)
            DstRt:   wr_idx = rt;
            DstLink: wr_idx = RA'(LINK_REG);
            default: wr_idx = rd;
        endcase
        case (reg_wsrc)
            WsrcAluOut: wr_data = alu_out_q;
            WsrcMdr:    wr_data = mdr_q;
            WsrcSeq:    wr_data = inst_seq_addr;
            default:    wr_data = '0;
        endcase
    end

`ifdef DP_RF_BYPASS_EN
    assign rs_val = (wr_en && (wr_idx == rs)) ? wr_data : rf_q[rs];
    assign rt_val = (wr_en && (wr_idx == rt)) ? wr_data : rf_q[rt];
`else
    assign rs_val = rf_q[rs];
    assign rt_val = rf_q[rt];
`endif

    assign output_data = rs_val;
    assign rf_addr     = rs_val;
    assign rf_data     = rt_val;
    assign alu_out     = alu_out_q;

    // ALU operand selection and operation; all results wrap to W bits.
    always_comb begin
        case (alu_src_a)
            SrcAReg: op_a = a_q;
            SrcAPc:  op_a = inst_addr;
            SrcASeq: op_a = inst_seq_addr;
            default: op_a = '0;
        endcase
        case (alu_src_b)
            SrcBReg: op_b = b_q;
            SrcBOne: op_b = W'(1);
            SrcBImm: op_b = imm_sext;
            default: op_b = '0;
        endcase
        case (alu_op)
            AluAdd:   alu_result = op_a + op_b;
            AluSub:   alu_result = op_a - op_b;
            AluAnd:   alu_result = op_a & op_b;
            AluOr:    alu_result = op_a | op_b;
            AluNot:   alu_result = ~op_a;
            AluTcp:   alu_result = ~op_a + 1'b1;
            AluShl:   alu_result = op_a << 1;
            AluShr:   alu_result = {op_a[W-1], op_a[W-1:1]};
            AluLhi:   alu_result = op_b << (W / 2);
            AluPassB: alu_result = op_b;
            default:  alu_result = '0;
        endcase
    end

    // Signed comparison of the A and B latches.
    always_comb begin
        if (a_q == b_q) begin
            alu_cmp = CmpEq;
        end else if ($signed(a_q) > $signed(b_q)) begin
            alu_cmp = CmpGt;
        end else begin
            alu_cmp = CmpLt;
        end
    end

    // Register file storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                rf_q[i] <= '0;
            end
        end else if (wr_en) begin
            rf_q[wr_idx] <= wr_data;
        end
    end

    // Datapath latches; A/B read through the current (old) IR fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q      <= '0;
            mdr_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
        end else begin
            if (ir_write)  ir_q  <= instruction;
            if (mdr_write) mdr_q <= mem_data;
            if (ab_write) begin
                a_q <= rs_val;
                b_q <= rt_val;
            end
            // The multiplier owns ALUOut from start until DONE retires.
            if (mul_load) begin
                alu_out_q <= mul_product;
            end else if (alu_out_write && !(mul_busy || mul_done)) begin
                alu_out_q <= alu_result;
            end
        end
    end

    dp_iter_mul #(
        .Width(W)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .op_a    (a_q),
        .op_b    (b_q),
        .busy    (mul_busy),
        .done    (mul_done),
        .load    (mul_load),
        .product (mul_product)
    );

endmodule
